lfsr_sequencer: RTL

//  Parametrised LFSR sequence generator with runtime Fibonacci/Galois mode, seed load,
//  run/stop control, all-zero lockup recovery and measured-period reporting.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_next.sv | 22 ++
 rtl/lfsr_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR sequencer: step mode and control FSM encoding.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } lfsr_fsm_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step LFSR update, right-shifting, Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] FTAPS = 4'b0011,
  parameter logic [WIDTH-1:0] GTAPS = 4'b1100
) (
  input  logic [WIDTH-1:0] state_i,
  input  lfsr_mode_e       mode_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = '0;
    if (mode_i == LFSR_GAL)
      next_o = (state_i >> 1) ^ ({WIDTH{state_i[0]}} & GTAPS);
    else
      next_o = {^(state_i & FTAPS), state_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/lfsr_sequencer.sv
// LFSR sequence generator with seed load, run/stop control, all-zero lockup
// recovery and measured-period reporting on return to the seed.
module lfsr_sequencer
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] FTAPS      = 4'b0011,
  parameter logic [WIDTH-1:0] GTAPS      = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'b0001,
  parameter int               CNT_W      = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_en_i,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o,
  output logic             running_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] period_o,
  output logic             lockup_o
);

  lfsr_fsm_e        fsm_q;
  lfsr_mode_e       mode_q;
  logic [WIDTH-1:0] state_q, seed_q, next_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc_d, period_q;
  logic             wrap_q, lockup_q;

  lfsr_next #(
    .WIDTH (WIDTH),
    .FTAPS (FTAPS),
    .GTAPS (GTAPS)
  ) u_next (
    .state_i (state_q),
    .mode_i  (mode_q),
    .next_o  (next_d)
  );

  // Period counter sticks at all-ones rather than wrapping on long sequences.
  assign cnt_inc_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= S_IDLE;
      mode_q   <= LFSR_FIB;
      state_q  <= RESET_SEED;
      seed_q   <= RESET_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
      if (load_i) begin
        // Load overrides everything; a pending recovery is abandoned silently.
        state_q <= seed_i;
        seed_q  <= seed_i;
        mode_q  <= lfsr_mode_e'(mode_i);
        cnt_q   <= '0;
        if (fsm_q == S_RECOVER) fsm_q <= S_RUN;
      end else begin
        case (fsm_q)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              mode_q <= lfsr_mode_e'(mode_i);
              fsm_q  <= S_RUN;
            end
          end
          S_RUN: begin
            if (stop_i) begin
              fsm_q <= S_IDLE;
            end else if (state_q == '0) begin
              fsm_q <= S_RECOVER;
            end else if (step_en_i) begin
              state_q <= next_d;
              if (next_d == seed_q) begin
                wrap_q   <= 1'b1;
                period_q <= cnt_inc_d;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_inc_d;
              end
            end
          end
          S_RECOVER: begin
            state_q  <= RESET_SEED;
            seed_q   <= RESET_SEED;
            cnt_q    <= '0;
            lockup_q <= 1'b1;
            fsm_q    <= S_RUN;
          end
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign state_o   = state_q;
  assign bit_o     = state_q[0];
  assign running_o = (fsm_q != S_IDLE);
  assign wrap_o    = wrap_q;
  assign period_o  = period_q;
  assign lockup_o  = lockup_q;

endmodule
